display_scanner: RTL

Time-multiplexed scanner for the 4-digit common-anode 7-segment display. Takes four BCD digits plus a per-digit blink mask, snapshots them once per scan frame, and presents one digit at a time as a 4-bit code with the matching active-low anode strobe. Sits directly upstream of the digit-to-cathode decoder. That decoder renders code 10 as a dark digit and has no defined output for codes 11-15, so this block never emits codes above 10.

---
 rtl/display_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Once per scan frame it snapshots four BCD digits and a per-digit blink mask.
// It then presents one digit at a time as a 4-bit code (0-9, or 10 = dark)
// together with the matching active-low anode strobe. Codes above 10 are never
// emitted because the downstream decoder has no defined output for them.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= GUARD+2)
//   GUARD        leading cycles of each slot with all anodes off (>= 1)
//   BLINK_DIV    slot ticks per blink half-period (>= 1)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   d0..d3       input digits, d0 = rightmost (anode 0), d3 = leftmost (anode 3)
//   blink_mask   bit i set = digit i blinks
//   digit        registered code for the decoder: 0-9 or 10 (blank)
//   an           registered anode enables, active-low, at most one low
//   frame_start  registered one-cycle pulse when a new snapshot is loaded
//
// Build option:
//   DISPLAY_SCANNER_LZB_EN  when defined, a leading zero in d3 is shown blank
// ---------------------------------------------------------------------------
module display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] blink_mask,
    output logic [3:0] digit,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0]  GUARD_END = PRE_W'(GUARD);
    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(BLINK_DIV - 1);
    localparam logic [3:0]        BLANK     = 4'd10;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [1:0]        slot_q, slot_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              bph_q, bph_d;
    logic [3:0][3:0]   frame_q, frame_d;
    logic [3:0]        fmask_q, fmask_d;
    logic [3:0]        digit_q, digit_d;
    logic [3:0]        an_q, an_d;
    logic              frame_start_q, frame_start_d;

    logic slot_tick;
    logic snap;

    // Anything outside BCD is stored as the blank code so the decoder never
    // sees 11-15.
    function automatic logic [3:0] sanitize(input logic [3:0] value);
        return (value > 4'd9) ? BLANK : value;
    endfunction

    always_comb begin
        slot_tick = (pre_q == PRE_MAX);
        snap      = slot_tick && (slot_q == 2'd3);

        pre_d  = slot_tick ? '0 : pre_q + 1'b1;
        slot_d = slot_tick ? slot_q + 2'd1 : slot_q;

        bcnt_d = bcnt_q;
        bph_d  = bph_q;
        if (slot_tick) begin
            if (bcnt_q == BCNT_MAX) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // Inputs are only looked at on the 3->0 tick, so a frame never tears.
        frame_d = frame_q;
        fmask_d = fmask_q;
        if (snap) begin
            frame_d[0] = sanitize(d0);
            frame_d[1] = sanitize(d1);
            frame_d[2] = sanitize(d2);
            frame_d[3] = sanitize(d3);
            fmask_d    = blink_mask;
        end

        frame_start_d = snap;

        // Computed from the current slot state, so the registered digit switches
        // on the same edge that the new slot's guard interval starts.
        if (bph_q && fmask_q[slot_q]) begin
            digit_d = BLANK;
        end
`ifdef DISPLAY_SCANNER_LZB_EN
        else if ((slot_q == 2'd3) && (frame_q[3] == 4'd0)) begin
            digit_d = BLANK;
        end
`endif
        else begin
            digit_d = frame_q[slot_q];
        end

        if (pre_q < GUARD_END) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~(4'b0001 << slot_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q         <= '0;
            slot_q        <= 2'd3;
            bcnt_q        <= '0;
            bph_q         <= 1'b0;
            frame_q       <= {4{BLANK}};
            fmask_q       <= 4'b0000;
            digit_q       <= BLANK;
            an_q          <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            slot_q        <= slot_d;
            bcnt_q        <= bcnt_d;
            bph_q         <= bph_d;
            frame_q       <= frame_d;
            fmask_q       <= fmask_d;
            digit_q       <= digit_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digit       = digit_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
